prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: program-memory address width.
REQ-002 SHALL have parameter DATA_W, default 16: program word width; fixed at 2 bytes.
REQ-003 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_start, input, 1: one-cycle pulse that arms a new load.
REQ-006 SHALL have port i_valid, input, 1: a byte is offered on i_byte.
REQ-007 SHALL have port i_byte, input, 8: the offered stream byte.
REQ-008 SHALL have port o_ready, output, 1: the loader accepts i_byte this cycle.
REQ-009 SHALL have port o_we, output, 1: memory write strobe.
REQ-010 SHALL have port o_addr, output, ADDR_W: memory write address.
REQ-011 SHALL have port o_data, output, DATA_W: memory write data.
REQ-012 SHALL have port o_busy, output, 1: load in progress; the CPU is held in reset while high.
REQ-013 SHALL have port o_done, output, 1: the last load completed.
REQ-014 SHALL have port o_err, output, 1: the last load failed.

Function
REQ-015 SHALL be a writer for the synchronous 1-cycle-read program memory: it fills words 0..L-1 from a byte stream.
REQ-016 SHALL accept frames in this format: LEN_HI, LEN_LO (L = word count, big-endian), then 2L data bytes, each word high byte first.
REQ-017 SHALL accept a byte on any cycle where i_valid and o_ready are both high; it SHALL NOT accept a byte without i_valid.
REQ-018 SHALL use states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM (only when the feature is compiled in), and END.
REQ-019 SHALL go IDLE->LEN_HI on i_start, and END->LEN_HI on i_start; i_start SHALL be ignored in every other state.
REQ-020 SHALL drive o_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CSUM.
REQ-021 SHALL check the length on acceptance of LEN_LO: L=0 or L>2**ADDR_W -> o_err=1, go to END, and perform no writes.
REQ-022 SHALL, on acceptance of the DATA_LO byte, pulse o_we for exactly the next cycle, with o_addr = word index and o_data = {hi, lo}.
REQ-023 SHALL start the word index at 0 and increment it by 1 after each write; after word L-1 it SHALL go to CSUM if compiled in, else to END.
REQ-024 SHALL hold o_addr and o_data stable between writes; o_we SHALL be 0 in all cycles except the write cycle.
REQ-025 SHALL make L=2**ADDR_W legal: the last address is all-ones, and the index SHALL NOT wrap to 0 before END.
REQ-026 SHALL drive o_busy=1 from the first cycle of LEN_HI until the cycle END is entered.
REQ-027 SHALL set o_done=1 in END only if o_err=0; i_start SHALL clear o_done and o_err.
REQ-028 SHALL allow back-to-back bytes (i_valid held high) at 1 byte/cycle with no stalls.

Reset
REQ-029 SHALL, while i_rst_n=0: state=IDLE, o_ready=0, o_we=0, o_addr=0, o_data=0, o_busy=0, o_done=0, o_err=0, index=0, checksum=0.
REQ-030 SHALL abort any reset that arrives mid-load without a partial write strobe; memory contents are then undefined and a new i_start is required.

Configuration
REQ-031 SHALL, with PROG_LOADER_CHECKSUM_EN defined, keep a running 8-bit sum mod 256 of all LEN and data bytes, and accept one more byte in CSUM; sum+byte != 0 -> o_err=1, then go to END.
REQ-032 SHALL, without PROG_LOADER_CHECKSUM_EN, have no CSUM state and no sum register; o_err SHALL then report only length errors.

Structure
REQ-033 SHALL place the state enum type and the byte width constant (8) in the shared package prog_loader_pkg.
REQ-034 SHALL be a single module; checksum logic SHALL be inline, with no sub-module.

Verification
REQ-035 SHALL test: i_start, then bytes 00 02 12 34 AB CD -> writes (0,1234), (1,ABCD), then o_done=1, o_err=0, o_busy=0.
REQ-036 SHALL test: i_start, then bytes 00 00 -> o_err=1, o_done=0, and no o_we.
REQ-037 SHALL test: i_start, then bytes 04 01 -> o_err=1 with ADDR_W=10, and no o_we.
REQ-038 SHALL test: L=1024 with data = index -> last write at address 3FF with data 03FF, then o_done=1.
REQ-039 SHALL test: i_rst_n dropped after the DATA_HI byte of word 5 -> all outputs go to reset values at once, and no write occurs to address 5.
REQ-040 SHALL test, with CHECKSUM_EN: bytes 00 01 00 01 FE -> o_done=1; and last byte FF -> o_err=1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-memory loader.
// PROG_LOADER_CHECKSUM_EN adds the CSUM state to the state encoding.
package prog_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int LEN_W  = 2 * BYTE_W;

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM, ST_END
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_END
    } state_t;
`endif

endpackage

// File: rtl/prog_loader.sv
// Byte-stream writer for a synchronous program memory: LEN_HI, LEN_LO, then 2L data bytes.
// Optional feature macro PROG_LOADER_CHECKSUM_EN: trailing 8-bit checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_valid,
    input  logic [7:0]        i_byte,
    output logic              o_ready,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int MAX_LEN = 2 ** ADDR_W;

    state_t              r_state;
    logic [BYTE_W-1:0]   r_len_hi;
    logic [BYTE_W-1:0]   r_hi;
    logic [LEN_W-1:0]    r_len;
    logic [ADDR_W:0]     r_idx;   // one extra bit so L = 2**ADDR_W never wraps
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   r_sum;
    logic [BYTE_W-1:0]   w_sum_next;
`endif

    logic                w_ready;
    logic                w_accept;
    logic [LEN_W-1:0]    w_len;
    logic                w_len_bad;
    logic                w_last;

    always_comb begin
        // NOTE: default first so every path assigns w_ready and no latch is inferred.
        w_ready = 1'b0;
        case (r_state)
            ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO: w_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CSUM:                                       w_ready = 1'b1;
`endif
            default:                                       w_ready = 1'b0;
        endcase
    end

    assign w_accept  = i_valid && w_ready;
    assign w_len     = {r_len_hi, i_byte};
    assign w_len_bad = (w_len == '0) || (int'(w_len) > MAX_LEN);
    assign w_last    = (int'(r_idx) + 1 == int'(r_len));
`ifdef PROG_LOADER_CHECKSUM_EN
    assign w_sum_next = r_sum + i_byte;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_len_hi <= '0;
            r_hi     <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum    <= '0;
`endif
        end else begin
            // NOTE: non-blocking default makes the write strobe a single-cycle pulse.
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_END: begin
                    if (i_start) begin
                        r_state <= ST_LEN_HI;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_idx   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_sum   <= '0;
`endif
                    end
                end
                ST_LEN_HI: begin
                    if (w_accept) begin
                        r_len_hi <= i_byte;
                        r_state  <= ST_LEN_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_sum    <= w_sum_next;
`endif
                    end
                end
                ST_LEN_LO: begin
                    if (w_accept) begin
                        r_len <= w_len;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_sum <= w_sum_next;
`endif
                        if (w_len_bad) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_END;
                        end else begin
                            r_state <= ST_DATA_HI;
                        end
                    end
                end
                ST_DATA_HI: begin
                    if (w_accept) begin
                        r_hi    <= i_byte;
                        r_state <= ST_DATA_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_sum   <= w_sum_next;
`endif
                    end
                end
                ST_DATA_LO: begin
                    if (w_accept) begin
                        r_we   <= 1'b1;
                        r_addr <= r_idx[ADDR_W-1:0];
                        r_data <= {r_hi, i_byte};
                        r_idx  <= r_idx + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_sum  <= w_sum_next;
                        r_state <= w_last ? ST_CSUM : ST_DATA_HI;
`else
                        if (w_last) begin
                            r_state <= ST_END;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_DATA_HI;
                        end
`endif
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (w_accept) begin
                        r_state <= ST_END;
                        r_busy  <= 1'b0;
                        if (w_sum_next != '0) r_err  <= 1'b1;
                        else                  r_done <= 1'b1;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ready = w_ready;
    assign o_we    = r_we;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_err   = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected writes, a negedge monitor pops them.
module tb_prog_loader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              valid;
    logic [7:0]        byte_in;
    logic              ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              done;
    logic              err;

    int  n_vec = 0;
    int  n_err = 0;
    wr_t exp_q[$];
    logic [7:0] tb_sum;

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_valid (valid),
        .i_byte  (byte_in),
        .o_ready (ready),
        .o_we    (we),
        .o_addr  (addr),
        .o_data  (data),
        .o_busy  (busy),
        .o_done  (done),
        .o_err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", 32'(addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(addr), 32'(e.addr));
                check("write_data", 32'(data), 32'(e.data));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        tb_sum = '0;
    endtask

    task automatic send(input logic [7:0] b);
        bit taken;
        taken   = 1'b0;
        valid   = 1'b1;
        byte_in = b;
        for (int k = 0; k < 8 && !taken; k++) begin
            @(negedge clk);
            if (ready) begin
                @(posedge clk); #1;
                taken = 1'b1;
            end
        end
        valid = 1'b0;
        if (taken) tb_sum = tb_sum + b;
        else       check("ready_timeout", 32'(0), 32'(1));
    endtask

    task automatic send_word(input int idx, input logic [15:0] w);
        wr_t e;
        e.addr = ADDR_W'(idx);
        e.data = w;
        exp_q.push_back(e);
        send(w[15:8]);
        send(w[7:0]);
    endtask

    task automatic send_csum();
`ifdef PROG_LOADER_CHECKSUM_EN
        send(8'(-tb_sum));
`endif
    endtask

    task automatic expect_end(input string name, input logic exp_done, input logic exp_err);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_done"},  32'(done),  32'(exp_done));
        check({name, "_err"},   32'(err),   32'(exp_err));
        check({name, "_busy"},  32'(busy),  32'(0));
        check({name, "_ready"}, 32'(ready), 32'(0));
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        valid   = 1'b0;
        byte_in = '0;
        tb_sum  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'(0));
        check("rst_we",    32'(we),    32'(0));
        check("rst_addr",  32'(addr),  32'(0));
        check("rst_data",  32'(data),  32'(0));
        check("rst_busy",  32'(busy),  32'(0));
        check("rst_done",  32'(done),  32'(0));
        check("rst_err",   32'(err),   32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two-word frame, back-to-back bytes.
        pulse_start();
        check("load_busy",  32'(busy),  32'(1));
        check("load_ready", 32'(ready), 32'(1));
        send(8'h00); send(8'h02);
        send_word(0, 16'h1234);
        send_word(1, 16'hABCD);
        send_csum();
        expect_end("two_words", 1'b1, 1'b0);

        // Zero length.
        pulse_start();
        check("restart_done_clr", 32'(done), 32'(0));
        send(8'h00); send(8'h00);
        expect_end("len_zero", 1'b0, 1'b1);

        // Length one past the memory size.
        pulse_start();
        check("restart_err_clr", 32'(err), 32'(0));
        send(8'h04); send(8'h01);
        expect_end("len_1025", 1'b0, 1'b1);

        // Full memory, data = index.
        pulse_start();
        send(8'h04); send(8'h00);
        for (int i = 0; i < 1024; i++) send_word(i, 16'(i));
        send_csum();
        expect_end("len_1024", 1'b1, 1'b0);
        check("len_1024_last_addr", 32'(addr), 32'h3FF);
        check("len_1024_last_data", 32'(data), 32'h03FF);

        // Reset after the high byte of word 5.
        pulse_start();
        send(8'h00); send(8'h08);
        for (int i = 0; i < 5; i++) send_word(i, 16'h5A00 + 16'(i));
        send(8'h77);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'(0));
        check("abort_we",    32'(we),    32'(0));
        check("abort_addr",  32'(addr),  32'(0));
        check("abort_data",  32'(data),  32'(0));
        check("abort_busy",  32'(busy),  32'(0));
        check("abort_done",  32'(done),  32'(0));
        check("abort_err",   32'(err),   32'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_idle_ready", 32'(ready), 32'(0));
        check("abort_idle_busy",  32'(busy),  32'(0));

`ifdef PROG_LOADER_CHECKSUM_EN
        pulse_start();
        send(8'h00); send(8'h01);
        send_word(0, 16'h0001);
        send(8'hFE);
        expect_end("csum_ok", 1'b1, 1'b0);

        pulse_start();
        send(8'h00); send(8'h01);
        send_word(0, 16'h0001);
        send(8'hFF);
        expect_end("csum_bad", 1'b0, 1'b1);
`else
        pulse_start();
        send(8'h00); send(8'h01);
        send_word(0, 16'hBEEF);
        expect_end("after_abort", 1'b1, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("pending_writes", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
